ctrl_trace_encoder: RTL and testbench
=====================================

# ctrl_trace_encoder

Debug trace block for the McCoy core. It sits beside the opcode decoder and watches the decoded control bundle (bez, ja, op1, op2, writeReg, writex8, x8Sel) on every retired instruction. It re-encodes each bundle into a 3-bit opcode class and buffers the 4-bit trace symbols in a small FIFO. It drains them over a valid/ready port to the pin-limited debug output, with overflow accounting.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- retire  in  1  one instruction retires this cycle; the bundle is valid.
- bez, ja, op1, writeReg, writex8  in  1 each  decoded control bits.
- op2  in  2  decoded control.
- x8Sel  in  2  decoded control.
- trc_en  in  1  capture enable; when 0, retires are ignored and not counted as drops.
- clr  in  1  synchronous clear of FIFO, counters and flags; wins over all other activity.
- trc_data  out  4  head-of-FIFO symbol.
- trc_valid  out  1  FIFO not empty.
- trc_ready  in  1  consumer accepts trc_data this cycle.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  DROP_W  dropped captures; saturates at all-ones.
- illegal_seen  out  1  sticky: an unrecognised bundle was captured.

## Operation
Symbol encoding: bit 3 is the error/marker flag and bits 2:0 are the class. Bundle bits not listed below must be 0 for a match.
- bez=1, op2=1 -> 4'b0000 (BEZ).
- ja=1, op1=1, op2=1 -> 4'b0010 (JA).
- writex8=1, x8Sel=1 -> 4'b0001 (LI/ADD class). These two opcodes share a bundle and are reported as one class.
- writex8=1, x8Sel=0 -> 4'b0100 (LR).
- op1=1, writex8=1, x8Sel=2 -> 4'b0101 (NOT).
- writeReg=1 -> 4'b0110 (SR).
- All zero -> 4'b0111 (NOP/default).
- Any other bundle -> 4'b1000 (ILLEGAL), and illegal_seen is set.
- 4'b1111 is the overflow marker. It is never produced by encoding.

Capture and FIFO:
- A capture request is trc_en & retire.
- push_ok = !full | pop, where pop = trc_valid & trc_ready.
- A request with push_ok writes the encoded symbol at the tail.
- A request without push_ok is dropped: drop_cnt increments (saturating) and ovf_pending is set.
- While ovf_pending=1 and push_ok=1, the marker 4'b1111 is pushed and ovf_pending clears. The marker has priority over a same-cycle capture.
- A capture that coincides with a marker push is dropped and drop_cnt increments. It does not re-set ovf_pending, because the marker already records the gap.
- Pointers wrap modulo DEPTH. fifo_level tracks push/pop, with simultaneous push and pop leaving it unchanged.
- Pop when empty is impossible, since trc_valid=0.

## Timing
- Reset and clr give: trc_valid=0, trc_data=0, fifo_level=0, drop_cnt=0, illegal_seen=0, ovf_pending=0, pointers 0.
- Latency: a capture at edge N into an empty FIFO gives trc_valid=1 with that symbol after edge N, and it is poppable in cycle N+1.
- trc_data is registered from FIFO storage and holds stable while trc_valid=1 and trc_ready=0.
- Full plus capture plus pop in the same cycle: the pop frees a slot, the capture is stored, no drop, and fifo_level stays DEPTH.
- illegal_seen is set on the edge that captures the illegal bundle. A dropped illegal bundle does not set it.
- If clr and retire are asserted in the same cycle, everything clears and the capture is discarded without counting.
- rst_n deasserted mid-stream: everything returns to reset values immediately, asynchronously.

## Test plan
- Reset, then retire the 7 legal bundles back-to-back with trc_ready=1 -> symbols 0,2,1,4,5,6,7 in order, each one cycle after capture, drop_cnt=0.
- Capture bundle bez=1, ja=1 -> symbol 4'b1000, and illegal_seen=1 until clr.
- trc_ready=0, with 6 LR retires and DEPTH=4 -> fifo_level=4, drop_cnt=2. Then trc_ready=1 -> 0100 x4, then 1111, then FIFO empty.
- FIFO full, with capture and pop in the same cycle -> no drop, fifo_level=4, new symbol appended.
- trc_en=0 during 3 retires -> no symbols, drop_cnt unchanged. Force 300 drops -> drop_cnt=255.
- Assert rst_n=0 asynchronously with 3 entries queued -> trc_valid=0 and fifo_level=0 before the next edge. clr with a simultaneous retire -> empty FIFO.

Source files
------------

// File: rtl/ctrl_trace_encoder.sv
// Debug trace encoder: classifies each retired control bundle into a 4-bit symbol
// and queues the symbols in a small FIFO drained over a valid/ready port.
module ctrl_trace_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     retire,
  input  logic                     bez,
  input  logic                     ja,
  input  logic                     op1,
  input  logic [1:0]               op2,
  input  logic                     writeReg,
  input  logic                     writex8,
  input  logic [1:0]               x8Sel,
  input  logic                     trc_en,
  input  logic                     clr,
  output logic [3:0]               trc_data,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     illegal_seen
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [3:0] SYM_ILLEGAL = 4'b1000;
  localparam logic [3:0] SYM_MARKER  = 4'b1111;

  // Bundle order: {bez, ja, op1, op2[1:0], writeReg, writex8, x8Sel[1:0]}
  function automatic logic [3:0] encode(input logic [8:0] b);
    logic [3:0] sym;
    case (b)
      9'b1_0_0_01_0_0_00: sym = 4'b0000;
      9'b0_1_1_01_0_0_00: sym = 4'b0010;
      9'b0_0_0_00_0_1_01: sym = 4'b0001;
      9'b0_0_0_00_0_1_00: sym = 4'b0100;
      9'b0_0_1_00_0_1_10: sym = 4'b0101;
      9'b0_0_0_00_1_0_00: sym = 4'b0110;
      9'b0_0_0_00_0_0_00: sym = 4'b0111;
      default:            sym = SYM_ILLEGAL;
    endcase
    return sym;
  endfunction

  logic [3:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              illegal_q, illegal_d;
  logic [3:0]        trc_data_q, trc_data_d;
  logic              trc_valid_q, trc_valid_d;

  logic [3:0]        sym_s, push_sym_s;
  logic              req_s, pop_s, full_s, push_ok_s, push_s, drop_s;

  // Capture arbitration, pointer/level/counter next state and next head symbol
  always_comb begin
    sym_s      = encode({bez, ja, op1, op2, writeReg, writex8, x8Sel});
    req_s      = trc_en & retire;
    pop_s      = trc_valid_q & trc_ready;
    full_s     = (level_q == LVL_FULL);
    push_ok_s  = ~full_s | pop_s;
    push_s     = 1'b0;
    push_sym_s = sym_s;
    drop_s     = 1'b0;
    ovf_d      = ovf_q;
    illegal_d  = illegal_q;

    // A pending overflow marker takes the free slot ahead of any capture
    if (ovf_q && push_ok_s) begin
      push_s     = 1'b1;
      push_sym_s = SYM_MARKER;
      ovf_d      = 1'b0;
      drop_s     = req_s;
    end else if (req_s && push_ok_s) begin
      push_s = 1'b1;
      if (sym_s == SYM_ILLEGAL) begin
        illegal_d = 1'b1;
      end else begin
        illegal_d = illegal_q;
      end
    end else if (req_s) begin
      drop_s = 1'b1;
      ovf_d  = 1'b1;
    end else begin
      push_s = 1'b0;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    level_d = level_q + LVL_W'(push_s) - LVL_W'(pop_s);

    if (drop_s && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end else begin
      drop_d = drop_q;
    end

    trc_valid_d = (level_d != {LVL_W{1'b0}});
    // The new head may be the slot being written on this very edge
    if (!trc_valid_d) begin
      trc_data_d = 4'b0000;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      trc_data_d = push_sym_s;
    end else begin
      trc_data_d = mem_q[rd_ptr_d];
    end
  end

  // State registers with asynchronous reset and synchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'b0000;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      level_q     <= {LVL_W{1'b0}};
      drop_q      <= {DROP_W{1'b0}};
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      trc_data_q  <= 4'b0000;
      trc_valid_q <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 4'b0000;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      level_q     <= {LVL_W{1'b0}};
      drop_q      <= {DROP_W{1'b0}};
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      trc_data_q  <= 4'b0000;
      trc_valid_q <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_sym_s;
      end else begin
        mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      trc_data_q  <= trc_data_d;
      trc_valid_q <= trc_valid_d;
    end
  end

  assign trc_data     = trc_data_q;
  assign trc_valid    = trc_valid_q;
  assign fifo_level   = level_q;
  assign drop_cnt     = drop_q;
  assign illegal_seen = illegal_q;

endmodule

// File: tb/tb_ctrl_trace_encoder.sv
// Self-checking bench for ctrl_trace_encoder: directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_ctrl_trace_encoder;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, retire, bez, ja, op1, writeReg, writex8, trc_en, clr, trc_ready;
  logic [1:0] op2, x8Sel;
  logic [3:0] trc_data;
  logic       trc_valid, illegal_seen;
  logic [2:0] fifo_level;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [3:0] mq[$];
  int         m_drop = 0;
  bit         m_ovf  = 1'b0;
  bit         m_ill  = 1'b0;

  // Bundle order: {bez, ja, op1, op2, writeReg, writex8, x8Sel}; BEZ, JA, LI, LR, NOT, SR, NOP
  logic [8:0] legal_b [7] = '{9'b100010000, 9'b011010000, 9'b000000101, 9'b000000100,
                              9'b001000110, 9'b000001000, 9'b000000000};

  ctrl_trace_encoder #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst_n(rst_n), .retire(retire), .bez(bez), .ja(ja), .op1(op1),
    .op2(op2), .writeReg(writeReg), .writex8(writex8), .x8Sel(x8Sel),
    .trc_en(trc_en), .clr(clr), .trc_data(trc_data), .trc_valid(trc_valid),
    .trc_ready(trc_ready), .fifo_level(fifo_level), .drop_cnt(drop_cnt),
    .illegal_seen(illegal_seen)
  );

  function automatic logic [3:0] ref_encode(input logic [8:0] b);
    bit         bz = b[8];
    bit         j  = b[7];
    bit         o1 = b[6];
    logic [1:0] o2 = b[5:4];
    bit         wr = b[3];
    bit         wx = b[2];
    logic [1:0] xs = b[1:0];
    if (b == 9'd0) return 4'h7;
    if (bz && o2 == 2'd1 && !j && !o1 && !wr && !wx && xs == 2'd0) return 4'h0;
    if (j && o1 && o2 == 2'd1 && !bz && !wr && !wx && xs == 2'd0) return 4'h2;
    if (wx && xs == 2'd1 && !bz && !j && !o1 && o2 == 2'd0 && !wr) return 4'h1;
    if (wx && xs == 2'd0 && !bz && !j && !o1 && o2 == 2'd0 && !wr) return 4'h4;
    if (o1 && wx && xs == 2'd2 && !bz && !j && o2 == 2'd0 && !wr) return 4'h5;
    if (wr && !bz && !j && !o1 && o2 == 2'd0 && !wx && xs == 2'd0) return 4'h6;
    return 4'h8;
  endfunction

  task automatic set_b(input logic [8:0] b);
    {bez, ja, op1, op2, writeReg, writex8, x8Sel} = b;
  endtask

  task automatic model_clear();
    mq.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
    m_ill  = 1'b0;
  endtask

  task automatic model_step();
    bit         req, pop, room;
    logic [3:0] s;
    if (clr) begin
      model_clear();
    end else begin
      req  = trc_en && retire;
      pop  = (mq.size() > 0) && trc_ready;
      room = (mq.size() < DEPTH) || pop;
      if (pop) void'(mq.pop_front());
      s = ref_encode({bez, ja, op1, op2, writeReg, writex8, x8Sel});
      if (m_ovf && room) begin
        mq.push_back(4'hF);
        m_ovf = 1'b0;
        if (req) m_drop++;
      end else if (req && room) begin
        mq.push_back(s);
        if (s == 4'h8) m_ill = 1'b1;
      end else if (req) begin
        m_drop++;
        m_ovf = 1'b1;
      end
      if (m_drop > 255) m_drop = 255;
    end
  endtask

  task automatic check(input string tag);
    logic       ev = (mq.size() != 0);
    logic [2:0] el = 3'(mq.size());
    logic [7:0] ed = 8'(m_drop);
    checks++;
    assert (trc_valid === ev) else begin
      errors++; $error("FAIL %s trc_valid got %0b exp %0b", tag, trc_valid, ev);
    end
    checks++;
    assert (fifo_level === el) else begin
      errors++; $error("FAIL %s fifo_level got %0d exp %0d", tag, fifo_level, el);
    end
    checks++;
    assert (drop_cnt === ed) else begin
      errors++; $error("FAIL %s drop_cnt got %0d exp %0d", tag, drop_cnt, ed);
    end
    checks++;
    assert (illegal_seen === m_ill) else begin
      errors++; $error("FAIL %s illegal_seen got %0b exp %0b", tag, illegal_seen, m_ill);
    end
    if (mq.size() != 0) begin
      checks++;
      assert (trc_data === mq[0]) else begin
        errors++; $error("FAIL %s trc_data got %h exp %h", tag, trc_data, mq[0]);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rst_n = 1'b0; retire = 1'b0; trc_en = 1'b1; clr = 1'b0; trc_ready = 1'b0;
    set_b(9'd0);
    #12;
    check("reset");
    check_val("reset_data", {4'h0, trc_data}, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // Legal bundles back-to-back with the consumer always ready
    trc_ready = 1'b1; retire = 1'b1;
    for (int k = 0; k < 7; k++) begin
      set_b(legal_b[k]);
      tick("legal");
    end
    retire = 1'b0;
    repeat (2) tick("legal_idle");

    // Illegal bundle stays flagged until clr
    retire = 1'b1; set_b(9'b110000000);
    tick("illegal");
    retire = 1'b0;
    repeat (3) tick("ill_hold");
    clr = 1'b1; tick("clr"); clr = 1'b0;
    check_val("clr_data", {4'h0, trc_data}, 8'h00);

    // Overflow: six LR captures into a stalled FIFO, then drain
    trc_ready = 1'b0; retire = 1'b1; set_b(legal_b[3]);
    repeat (6) tick("ovf_fill");
    retire = 1'b0;
    check_val("ovf_level", {5'd0, fifo_level}, 8'd4);
    check_val("ovf_drops", drop_cnt, 8'd2);
    trc_ready = 1'b1;
    repeat (6) tick("ovf_drain");
    trc_ready = 1'b0;

    // Full FIFO with capture and pop in the same cycle
    retire = 1'b1; set_b(legal_b[4]);
    repeat (4) tick("full");
    trc_ready = 1'b1; set_b(legal_b[5]);
    tick("full_pop");
    check_val("full_pop_level", {5'd0, fifo_level}, 8'd4);
    check_val("full_pop_drops", drop_cnt, 8'd2);
    retire = 1'b0;
    repeat (5) tick("drain2");
    trc_ready = 1'b0;

    // Capture disabled: retires ignored and not counted
    trc_en = 1'b0; retire = 1'b1;
    repeat (3) tick("en_off");
    check_val("en_off_level", {5'd0, fifo_level}, 8'd0);
    trc_en = 1'b1;

    // Drop counter saturation
    repeat (305) tick("sat");
    check_val("sat_drops", drop_cnt, 8'hFF);
    retire = 1'b0; clr = 1'b1; tick("clr2"); clr = 1'b0;

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      int k;
      retire    = ($urandom_range(0, 3) != 0);
      trc_en    = ($urandom_range(0, 7) != 0);
      trc_ready = $urandom_range(0, 1);
      clr       = ($urandom_range(0, 63) == 0);
      k = $urandom_range(0, 8);
      if (k < 7) set_b(legal_b[k]);
      else set_b(9'($urandom));
      tick("rand");
    end
    clr = 1'b1; retire = 1'b0; trc_en = 1'b1; trc_ready = 1'b0;
    tick("clr3"); clr = 1'b0;

    // Asynchronous reset with entries queued
    retire = 1'b1; set_b(legal_b[6]);
    repeat (3) tick("pre_rst");
    retire = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check("async_rst");
    check_val("async_rst_data", {4'h0, trc_data}, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // clr together with a retire discards the capture
    retire = 1'b1; set_b(legal_b[1]);
    repeat (2) tick("pre_clr");
    clr = 1'b1; set_b(legal_b[0]);
    tick("clr_retire");
    clr = 1'b0; retire = 1'b0;
    check_val("clr_retire_level", {5'd0, fifo_level}, 8'd0);
    tick("post_clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
